// File: rtl/arith_pkg.sv
// Shared types for the sequential arithmetic unit: operation codes, FSM states and request bundle.
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_t;

  typedef struct packed {
    op_t                  op;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } req_t;

endpackage

// File: rtl/seq_arith_unit_if.sv
// Request/result handshake bundle of seq_arith_unit; the unit connects through the slave modport.
interface seq_arith_unit_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RES_W = 2 * WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_m;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_m, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_m, out_err
  );

endinterface

// File: rtl/seq_mult_core.sv
// Shift-add multiplier: one multiplier bit per enabled cycle, LSB first; done_o flags the last step.
module seq_mult_core #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [RES_W-1:0] prod_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [RES_W-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CntW-1:0]  cnt_q;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Product is taken from acc_d so the caller can capture it on the final step's edge.
  assign prod_o = acc_d;
  assign done_o = en_i && (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      acc_q    <= '0;
      mcand_q  <= RES_W'(a_i);
      mplier_q <= b_i;
      cnt_q    <= '0;
    end else if (en_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential add/sub/mul unit with valid/ready handshake. Multiplier present only when
// SEQ_ARITH_MUL_EN is defined; otherwise OP_MUL is reported as an illegal request.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_arith_unit_if.slave  bus_io
);

  if (RES_W != 2 * WIDTH) begin : g_bad_res_w
    $error("seq_arith_unit: RES_W must equal 2*WIDTH");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_arith_unit: WIDTH must be in 2..32");
  end

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             in_ready_q, out_valid_q, out_err_q;
  logic [RES_W-1:0] out_m_q;

  logic             accept;
  logic [RES_W-1:0] add_res, sub_res;
  logic [WIDTH:0]   diff;

  assign accept = (state_q == StIdle) && in_ready_q && bus_io.in_valid;

  always_comb begin
    add_res = RES_W'(a_q) + RES_W'(b_q);
    diff    = {1'b0, a_q} - {1'b0, b_q};
    sub_res = {{(RES_W - WIDTH - 1){diff[WIDTH]}}, diff};
  end

`ifdef SEQ_ARITH_MUL_EN
  logic [RES_W-1:0] mul_prod;
  logic             mul_done;

  // Operands are loaded straight from the bus on the accept edge.
  seq_mult_core #(
    .WIDTH (WIDTH),
    .RES_W (RES_W)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .en_i    ((state_q == StCalc) && (op_q == OP_MUL)),
    .a_i     (bus_io.in_a),
    .b_i     (bus_io.in_b),
    .prod_o  (mul_prod),
    .done_o  (mul_done)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_m_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            op_q       <= bus_io.in_op;
            a_q        <= bus_io.in_a;
            b_q        <= bus_io.in_b;
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          unique case (op_q)
            OP_ADD: begin
              out_m_q     <= add_res;
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
            OP_SUB: begin
              out_m_q     <= sub_res;
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
`ifdef SEQ_ARITH_MUL_EN
            OP_MUL: begin
              if (mul_done) begin
                out_m_q     <= mul_prod;
                out_err_q   <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= StDone;
              end
            end
`endif
            default: begin
              out_m_q     <= '0;
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          endcase
        end
        StDone: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_m     = out_m_q;
  assign bus_io.out_err   = out_err_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit (WIDTH=5); expectations follow SEQ_ARITH_MUL_EN.
module tb_seq_arith_unit;
  import arith_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  seq_arith_unit_if #(.WIDTH(5)) bus ();

  seq_arith_unit #(.WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_ready"}, 32'(seen), 32'd1);
  endtask

  // Issue one request, measure latency, hold off out_ready for `stall` cycles, then retire it.
  task automatic run_op(input string tag, input op_t op, input logic [4:0] a, input logic [4:0] b,
                        input logic [9:0] exp_m, input logic exp_err, input int exp_lat,
                        input int stall);
    int lat;
    wait_ready(tag);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_op    = op_t'(2'd3);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid === 1'b1) break;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_m"}, 32'(bus.out_m), 32'(exp_m));
    check_eq({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
    check_eq({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_v"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_hold_m"}, 32'(bus.out_m), 32'(exp_m));
      check_eq({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_retire_v"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_retire_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int valid_seen;
    n_total       = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_m", 32'(bus.out_m), 32'd0);
    check_eq("rst_err", 32'(bus.out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_ready", 32'(bus.in_ready), 32'd1);

    run_op("add_max", OP_ADD, 5'd31, 5'd31, 10'd62, 1'b0, 1, 0);
    run_op("sub_neg", OP_SUB, 5'd3, 5'd5, 10'h3FE, 1'b0, 1, 0);
    run_op("sub_pos", OP_SUB, 5'd5, 5'd3, 10'd2, 1'b0, 1, 0);
    run_op("add_zero", OP_ADD, 5'd0, 5'd0, 10'd0, 1'b0, 1, 0);
    run_op("sub_zero", OP_SUB, 5'd0, 5'd31, 10'h3E1, 1'b0, 1, 0);
    run_op("bad_op", op_t'(2'd3), 5'd6, 5'd7, 10'd0, 1'b1, 1, 0);
`ifdef SEQ_ARITH_MUL_EN
    run_op("mul_max", OP_MUL, 5'd31, 5'd31, 10'd961, 1'b0, 5, 0);
    run_op("mul_zero", OP_MUL, 5'd0, 5'd17, 10'd0, 1'b0, 5, 0);
    run_op("mul_stall", OP_MUL, 5'd6, 5'd7, 10'd42, 1'b0, 5, 3);

    // Reset pulse during the third CALC cycle of a multiply.
    wait_ready("mid_rst");
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    bus.in_a     = 5'd6;
    bus.in_b     = 5'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
`else
    run_op("mul_off", OP_MUL, 5'd6, 5'd7, 10'd0, 1'b1, 1, 0);
    run_op("add_stall", OP_ADD, 5'd6, 5'd7, 10'd13, 1'b0, 1, 3);

    // Reset pulse while a result is waiting in DONE.
    wait_ready("mid_rst");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_ADD;
    bus.in_a      = 5'd3;
    bus.in_b      = 5'd4;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_pre_v", 32'(bus.out_valid), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    #2;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_rel_rdy", 32'(bus.in_ready), 32'd1);
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid === 1'b1) valid_seen++;
      @(posedge clk);
      #1;
    end
    check_eq("mid_rst_no_out", 32'(valid_seen), 32'd0);
    run_op("post_rst_add", OP_ADD, 5'd1, 5'd1, 10'd2, 1'b0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 Parameter WIDTH, default 5, operand width in bits (legal 2..32).
REQ-002 Parameter RES_W, default 2*WIDTH, result width; SHALL equal 2*WIDTH (elaboration error otherwise).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  operand/op request valid.
REQ-006 in_ready  out  1  unit can accept a request.
REQ-007 in_op  in  op_t  operation select (OP_ADD, OP_SUB, OP_MUL).
REQ-008 in_a, in_b  in  WIDTH  unsigned operands.
REQ-009 out_valid  out  1  result valid.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 out_m  out  RES_W  result.
REQ-012 out_err  out  1  request was illegal; out_m is 0.

Function
REQ-013 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: in_valid=1 -> latch op/a/b, clear accumulator and counter, go CALC; else stay.
REQ-015 CALC for OP_ADD/OP_SUB/illegal: one cycle, then DONE (out_valid rises 1 edge after accept).
REQ-016 CALC for OP_MUL: shift-add, one multiplier bit per cycle, LSB first, WIDTH cycles, then DONE (out_valid rises WIDTH edges after accept).
REQ-017 OP_ADD: out_m = zero-extended a+b (carry kept in bit WIDTH).
REQ-018 OP_SUB: out_m = a-b as two's complement, sign-extended to RES_W (3-5 -> all-ones minus 1).
REQ-019 OP_MUL: out_m = unsigned a*b, exact in RES_W bits.
REQ-020 in_op value outside op_t, or OP_MUL with multiplier compiled out: out_err=1, out_m=0, ADD latency.
REQ-021 DONE: out_valid=1, out_m/out_err stable until out_valid&out_ready; then IDLE next edge.
REQ-022 No request accepted in the DONE->IDLE transition cycle; back-to-back throughput is one result per (latency+2) cycles.
REQ-023 in_a/in_b/in_op changes while not in IDLE SHALL NOT affect the in-flight result.
REQ-024 out_ready held high before out_valid SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=0 while asserted, out_valid=0, out_m=0, out_err=0, counter=0.
REQ-026 Reset mid-CALC or mid-DONE SHALL discard the operation; no result emitted afterwards.
REQ-027 in_ready=1 from the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SEQ_ARITH_MUL_EN defined: OP_MUL executes per REQ-016/019.
REQ-029 Macro SEQ_ARITH_MUL_EN undefined: multiplier core and counter not instantiated; OP_MUL treated as illegal per REQ-020.

Structure
REQ-030 Package arith_pkg SHALL hold op_t enum {OP_ADD, OP_SUB, OP_MUL}, state enum, and struct req_t {op, a, b} parametrised via package constant DEF_WIDTH=5.
REQ-031 Sub-module seq_mult_core (shift-add datapath: accumulator, multiplicand shift, bit counter, done pulse), instantiated only under SEQ_ARITH_MUL_EN.
REQ-032 Top module SHALL contain FSM, add/sub datapath, output register, handshake.

Verification (WIDTH=5)
REQ-033 OP_ADD a=31 b=31, out_ready=1 -> out_m=62, out_err=0, out_valid 1 edge after accept.
REQ-034 OP_SUB a=3 b=5 -> out_m=10'h3FE; OP_SUB a=5 b=3 -> out_m=2.
REQ-035 OP_MUL a=31 b=31 (macro on) -> out_m=961 after 5 edges; a=0 b=17 -> out_m=0 after 5 edges.
REQ-036 OP_MUL a=6 b=7, out_ready low 3 cycles after out_valid -> out_m=42 held stable, in_ready=0 throughout, IDLE one edge after out_ready=1.
REQ-037 rst_n pulsed low on 3rd CALC cycle of OP_MUL -> out_valid never asserts, in_ready=1 after release, next OP_ADD 1+1 -> 2.
REQ-038 Macro off, OP_MUL a=6 b=7, and in_op=3 -> out_err=1, out_m=0, 1-edge latency each.
